arm_mc_controller: RTL and testbench

- Control unit for the multicycle generation of the ARM core; replaces the single-cycle decoder.
- Combines the main decoder, ALU decoder, PC logic, condition check and NZCV flag register.
- A Moore state machine sequences each instruction over 3–5 cycles on a shared memory and ALU.
- Parametrised ALU command set; adds conditional execution and correct per-op flag writes.

---
 rtl/arm_mc_controller_pkg.sv | 108 ++++++++++
 rtl/arm_mc_controller_if.sv | 35 +++
 rtl/arm_mc_controller_cond_unit.sv | 41 ++++
 rtl/arm_mc_controller.sv | 137 +++++++++++++
 tb/tb_arm_mc_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit: FSM states,
// condition codes, data-processing commands, ALU controls and mux selects.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] SRCA_RD1   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_8      = 2'b00;
    localparam logic [1:0] IMM_12     = 2'b01;
    localparam logic [1:0] IMM_24     = 2'b10;

    typedef struct packed {
        logic [2:0] aluCtl;
        logic [1:0] flagW;
        logic       writesReg;
    } alu_dec_t;

    // nzcv = {N, Z, C, V}; the NV encoding (1111) never executes.
    function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, ok;
        {n, z, c, v} = nzcv;
        ok = 1'b0;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CS: ok = c;
            COND_CC: ok = !c;
            COND_MI: ok = n;
            COND_PL: ok = !n;
            COND_VS: ok = v;
            COND_VC: ok = !v;
            COND_HI: ok = c && !z;
            COND_LS: ok = !c || z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = !z && (n == v);
            COND_LE: ok = z || (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_dec_t aluDecode(input logic [5:0] funct, input logic ext);
        alu_dec_t d;
        logic s;
        s = funct[0];
        d = '{aluCtl: ALU_ADD, flagW: 2'b00, writesReg: 1'b0};
        case (funct[4:1])
            CMD_ADD: d = '{aluCtl: ALU_ADD, flagW: {s, s},    writesReg: 1'b1};
            CMD_SUB: d = '{aluCtl: ALU_SUB, flagW: {s, s},    writesReg: 1'b1};
            CMD_AND: d = '{aluCtl: ALU_AND, flagW: {s, 1'b0}, writesReg: 1'b1};
            CMD_ORR: d = '{aluCtl: ALU_ORR, flagW: {s, 1'b0}, writesReg: 1'b1};
            CMD_EOR: if (ext) d = '{aluCtl: ALU_EOR,   flagW: {s, 1'b0}, writesReg: 1'b1};
            CMD_MOV: if (ext) d = '{aluCtl: ALU_PASSB, flagW: {s, 1'b0}, writesReg: 1'b1};
            CMD_CMP: if (ext) d = '{aluCtl: ALU_SUB,   flagW: 2'b11,     writesReg: 1'b0};
            CMD_TST: if (ext) d = '{aluCtl: ALU_AND,   flagW: 2'b10,     writesReg: 1'b0};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Bundle between the control unit and the datapath: instruction fields and
// ALU flags in, enables and mux selects out.
interface arm_mc_controller_if #(parameter int EXT_ALU = 0);
    localparam int ALU_W = 2 + EXT_ALU;

    logic [3:0]       cond;
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [3:0]       rd;
    logic [3:0]       alu_flags;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_write;
    logic             adr_src;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       imm_src;
    logic [1:0]       reg_src;
    logic [ALU_W-1:0] alu_control;
    logic [3:0]       flags_q;

    modport master (
        input  cond, op, funct, rd, alu_flags,
        output pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, imm_src, reg_src, alu_control, flags_q
    );

    modport slave (
        output cond, op, funct, rd, alu_flags,
        input  pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
               alu_src_a, alu_src_b, imm_src, reg_src, alu_control, flags_q
    );
endinterface

// File: rtl/arm_mc_controller_cond_unit.sv
// NZCV flag register plus the condition-pass flop latched once per instruction
// in DECODE, so an instruction's own flag update cannot change its own predicate.
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] aluFlags,
    input  logic       captureEn,
    input  logic [1:0] flagWe,
    output logic [3:0] flagsQ,
    output logic       condExQ
);

    logic [1:0] flagPairQ [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            condExQ <= 1'b0;
        end else if (captureEn) begin
            condExQ <= condCheck(cond, flagsQ);
        end
    end

    // Pair 1 holds NZ, pair 0 holds CV; each has its own write enable.
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flagPairQ[gi] <= FLAG_RESET[2*gi +: 2];
            end else if (flagWe[gi] && condExQ) begin
                flagPairQ[gi] <= aluFlags[2*gi +: 2];
            end
        end
    end

    assign flagsQ = {flagPairQ[1], flagPairQ[0]};

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM plus main/ALU decoders sequencing each
// instruction over 3-5 cycles on a shared memory and ALU.
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter int         EXT_ALU    = 0,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input logic                clk,
    input logic                rst_n,
    arm_mc_controller_if.master bus
);

    localparam int ALU_W = 2 + EXT_ALU;

    state_t     stateQ;
    alu_dec_t   aluDec;
    logic       condExQ;
    logic [3:0] flagsQ;
    logic [1:0] flagWe;
    logic       rdIsPc;
    logic       pcW, irW, regW, memW, adrSrc, aluWr;
    logic [1:0] resSrc, srcA, srcB;
    logic [2:0] aluCtl;
    logic       unusedAluBits;

    assign aluDec = aluDecode(bus.funct, EXT_ALU != 0);
    assign rdIsPc = (bus.rd == 4'd15);
    assign flagWe = (stateQ == EXECR || stateQ == EXECI) ? aluDec.flagW : 2'b00;

    arm_cond_unit #(.FLAG_RESET(FLAG_RESET)) u_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .cond     (bus.cond),
        .aluFlags (bus.alu_flags),
        .captureEn(stateQ == DECODE),
        .flagWe   (flagWe),
        .flagsQ   (flagsQ),
        .condExQ  (condExQ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= FETCH;
        end else begin
            case (stateQ)
                FETCH:  stateQ <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_MEM:  stateQ <= MEMADR;
                        OP_DP:   stateQ <= bus.funct[5] ? EXECI : EXECR;
                        OP_BR:   stateQ <= bus.funct[4] ? FETCH : BRANCH;
                        default: stateQ <= FETCH;
                    endcase
                end
                MEMADR:       stateQ <= bus.funct[0] ? MEMRD : MEMWR;
                MEMRD:        stateQ <= MEMWB;
                EXECR, EXECI: stateQ <= ALUWB;
                default:      stateQ <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcW    = 1'b0;
        irW    = 1'b0;
        regW   = 1'b0;
        memW   = 1'b0;
        adrSrc = 1'b0;
        aluWr  = 1'b0;
        resSrc = RES_ALUOUT;
        srcA   = SRCA_RD1;
        srcB   = SRCB_RD2;
        aluCtl = ALU_ADD;
        case (stateQ)
            FETCH: begin
                irW    = 1'b1;
                pcW    = 1'b1;
                srcA   = SRCA_PC;
                srcB   = SRCB_FOUR;
                resSrc = RES_ALU;
            end
            DECODE: begin
                srcA   = SRCA_PC;
                srcB   = SRCB_FOUR;
                resSrc = RES_ALU;
            end
            MEMADR: srcB = SRCB_IMM;
            MEMRD:  adrSrc = 1'b1;
            MEMWB: begin
                // A load into R15 becomes a jump instead of a register write.
                resSrc = RES_RDATA;
                regW   = condExQ && !rdIsPc;
                pcW    = condExQ && rdIsPc;
            end
            MEMWR: begin
                adrSrc = 1'b1;
                memW   = condExQ;
            end
            EXECR: aluCtl = aluDec.aluCtl;
            EXECI: begin
                srcB   = SRCB_IMM;
                aluCtl = aluDec.aluCtl;
            end
            ALUWB: begin
                aluWr = condExQ && aluDec.writesReg;
                regW  = aluWr && !rdIsPc;
                pcW   = aluWr && rdIsPc;
            end
            BRANCH: begin
                srcB   = SRCB_IMM;
                resSrc = RES_ALU;
                pcW    = condExQ;
            end
            default: ;
        endcase
    end

    // Write enables are held low while reset is asserted even though the
    // state already reads FETCH.
    assign bus.pc_write    = pcW  && rst_n;
    assign bus.ir_write    = irW  && rst_n;
    assign bus.reg_write   = regW && rst_n;
    assign bus.mem_write   = memW && rst_n;
    assign bus.adr_src     = adrSrc;
    assign bus.result_src  = resSrc;
    assign bus.alu_src_a   = srcA;
    assign bus.alu_src_b   = srcB;
    assign bus.alu_control = aluCtl[ALU_W-1:0];
    assign bus.flags_q     = flagsQ;
    assign unusedAluBits   = ^aluCtl;

    assign bus.imm_src = (bus.op == OP_MEM) ? IMM_12 :
                         (bus.op == OP_BR)  ? IMM_24 : IMM_8;
    assign bus.reg_src = {bus.op == OP_MEM, bus.op == OP_BR};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Table-driven bench for arm_mc_controller: each record is one instruction with
// its expected state path, write enables and NZCV afterwards.
module tb_arm_mc_controller;
    import arm_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arm_mc_controller_if #(.EXT_ALU(1)) bus1 ();
    arm_mc_controller_if #(.EXT_ALU(0)) bus0 ();

    arm_mc_controller #(.EXT_ALU(1), .FLAG_RESET(4'b0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    arm_mc_controller #(.EXT_ALU(0), .FLAG_RESET(4'b0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));

    localparam int K_DPR = 0, K_DPI = 1, K_LDR = 2, K_STR = 3, K_BR = 4, K_SKIP = 5;

    typedef struct packed {
        logic [63:0] tag;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  aluFlags;
        logic [2:0]  kind;
        logic [2:0]  alu;
        logic        regW;
        logic        pcW;
        logic        memW;
        logic [3:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcW, irW, regW, memW, adr;
        logic [1:0] res, a, b;
        logic [2:0] alu;
        logic [1:0] imm, rsrc;
    } obs_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    obs_t expQ [$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic [63:0] tag, input logic [3:0] cond,
                                input logic [1:0] op, input logic [5:0] funct,
                                input logic [3:0] rd, input logic [3:0] af,
                                input int kind, input logic [2:0] alu,
                                input logic regW, input logic pcW, input logic memW,
                                input logic [3:0] flags);
        vec_t v;
        v = '{tag: tag, cond: cond, op: op, funct: funct, rd: rd, aluFlags: af,
              kind: 3'(kind), alu: alu, regW: regW, pcW: pcW, memW: memW, flags: flags};
        return v;
    endfunction

    function automatic int pathLen(input int kind);
        case (kind)
            K_LDR:   return 5;
            K_DPR, K_DPI, K_STR: return 4;
            K_BR:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic state_t pathState(input int kind, input int i);
        if (i == 0) return FETCH;
        if (i == 1) return DECODE;
        case (kind)
            K_DPR:   return (i == 2) ? EXECR : ALUWB;
            K_DPI:   return (i == 2) ? EXECI : ALUWB;
            K_LDR:   return (i == 2) ? MEMADR : (i == 3) ? MEMRD : MEMWB;
            K_STR:   return (i == 2) ? MEMADR : MEMWR;
            default: return BRANCH;
        endcase
    endfunction

    function automatic obs_t expectObs(input state_t s, input vec_t v);
        obs_t e;
        e      = '0;
        e.st   = s;
        e.imm  = (v.op == 2'b01) ? 2'b01 : (v.op == 2'b10) ? 2'b10 : 2'b00;
        e.rsrc = {v.op == 2'b01, v.op == 2'b10};
        case (s)
            FETCH:  begin e.pcW = 1'b1; e.irW = 1'b1; e.res = 2'b10; e.a = 2'b01; e.b = 2'b10; end
            DECODE: begin e.res = 2'b10; e.a = 2'b01; e.b = 2'b10; end
            MEMADR: e.b = 2'b01;
            MEMRD:  e.adr = 1'b1;
            MEMWB:  begin e.res = 2'b01; e.regW = v.regW; e.pcW = v.pcW; end
            MEMWR:  begin e.adr = 1'b1; e.memW = v.memW; end
            EXECR:  e.alu = v.alu;
            EXECI:  begin e.b = 2'b01; e.alu = v.alu; end
            ALUWB:  begin e.regW = v.regW; e.pcW = v.pcW; end
            BRANCH: begin e.b = 2'b01; e.res = 2'b10; e.pcW = v.pcW; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.st   = 4'(dut1.stateQ);
        o.pcW  = bus1.pc_write;
        o.irW  = bus1.ir_write;
        o.regW = bus1.reg_write;
        o.memW = bus1.mem_write;
        o.adr  = bus1.adr_src;
        o.res  = bus1.result_src;
        o.a    = bus1.alu_src_a;
        o.b    = bus1.alu_src_b;
        o.alu  = bus1.alu_control;
        o.imm  = bus1.imm_src;
        o.rsrc = bus1.reg_src;
        return o;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", what, act, exp);
        else passed++;
    endtask

    task automatic setInputs(input vec_t v);
        bus1.cond = v.cond; bus1.op = v.op; bus1.funct = v.funct;
        bus1.rd = v.rd; bus1.alu_flags = v.aluFlags;
        bus0.cond = v.cond; bus0.op = v.op; bus0.funct = v.funct;
        bus0.rd = v.rd; bus0.alu_flags = v.aluFlags;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        obs_t e;
        int   errs;
        errs = total - passed;
        setInputs(v);
        for (int i = 0; i < pathLen(int'(v.kind)); i++) begin
            expQ.push_back(expectObs(pathState(int'(v.kind), i), v));
            @(negedge clk);
            e = expQ.pop_front();
            check($sformatf("%s cyc%0d", v.tag, i), 32'(obs1()), 32'(e));
            @(posedge clk);
            #1;
        end
        check($sformatf("%s flags", v.tag), 32'(bus1.flags_q), 32'(v.flags));
        $display("vec %0d %s cycles=%0d flags=%b errors=%0d", idx, v.tag,
                 pathLen(int'(v.kind)), bus1.flags_q, total - passed - errs);
    endtask

    initial begin
        vec_t v;
        //               tag       cond     op     funct      rd  aluF     kind    alu  rW pW mW flags
        vecs[0]  = mk("ADDS",   4'hE, 2'b00, 6'b101001, 4'd1,  4'b0110, K_DPI,  3'd0, 1, 0, 0, 4'b0110);
        vecs[1]  = mk("ADD",    4'hE, 2'b00, 6'b001000, 4'd2,  4'b1111, K_DPR,  3'd0, 1, 0, 0, 4'b0110);
        vecs[2]  = mk("ANDS",   4'hE, 2'b00, 6'b100001, 4'd3,  4'b1011, K_DPI,  3'd2, 1, 0, 0, 4'b1010);
        vecs[3]  = mk("BEQ_Z0", 4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, K_BR,   3'd0, 0, 0, 0, 4'b1010);
        vecs[4]  = mk("ORRS",   4'hE, 2'b00, 6'b011001, 4'd8,  4'b0100, K_DPR,  3'd3, 1, 0, 0, 4'b0110);
        vecs[5]  = mk("BEQ_Z1", 4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, K_BR,   3'd0, 0, 1, 0, 4'b0110);
        vecs[6]  = mk("BL",     4'hE, 2'b10, 6'b010000, 4'd0,  4'b0000, K_SKIP, 3'd0, 0, 0, 0, 4'b0110);
        vecs[7]  = mk("OP11",   4'hE, 2'b11, 6'b000000, 4'd0,  4'b1111, K_SKIP, 3'd0, 0, 0, 0, 4'b0110);
        vecs[8]  = mk("STR",    4'hE, 2'b01, 6'b011000, 4'd4,  4'b0000, K_STR,  3'd0, 0, 0, 1, 4'b0110);
        vecs[9]  = mk("LDR_PC", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, K_LDR,  3'd0, 0, 1, 0, 4'b0110);
        vecs[10] = mk("LDR",    4'hE, 2'b01, 6'b011001, 4'd5,  4'b0000, K_LDR,  3'd0, 1, 0, 0, 4'b0110);
        vecs[11] = mk("STRNE",  4'h1, 2'b01, 6'b011000, 4'd4,  4'b0000, K_STR,  3'd0, 0, 0, 0, 4'b0110);
        vecs[12] = mk("SUBSNE", 4'h1, 2'b00, 6'b000101, 4'd9,  4'b1001, K_DPR,  3'd1, 0, 0, 0, 4'b0110);
        vecs[13] = mk("EORS",   4'hE, 2'b00, 6'b100011, 4'd10, 4'b1000, K_DPI,  3'd4, 1, 0, 0, 4'b1010);
        vecs[14] = mk("MOV",    4'hE, 2'b00, 6'b111010, 4'd6,  4'b1111, K_DPI,  3'd5, 1, 0, 0, 4'b1010);
        vecs[15] = mk("CMP",    4'hE, 2'b00, 6'b010101, 4'd0,  4'b0110, K_DPR,  3'd1, 0, 0, 0, 4'b0110);
        vecs[16] = mk("TST",    4'hE, 2'b00, 6'b110001, 4'd0,  4'b1001, K_DPI,  3'd2, 0, 0, 0, 4'b1010);
        vecs[17] = mk("UNDEF",  4'hE, 2'b00, 6'b001110, 4'd11, 4'b1111, K_DPR,  3'd0, 0, 0, 0, 4'b1010);
        vecs[18] = mk("ADD_PC", 4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, K_DPI,  3'd0, 0, 1, 0, 4'b1010);
        vecs[19] = mk("ADDGT",  4'hC, 2'b00, 6'b101000, 4'd7,  4'b0000, K_DPI,  3'd0, 0, 0, 0, 4'b1010);
        vecs[20] = mk("ADDLT",  4'hB, 2'b00, 6'b101000, 4'd7,  4'b0000, K_DPI,  3'd0, 1, 0, 0, 4'b1010);

        // Reset: FETCH selects, every write enable low, flags at reset value.
        rst_n = 1'b0;
        setInputs(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        begin
            obs_t r;
            r = '0;
            r.st = 4'(FETCH); r.res = 2'b10; r.a = 2'b01; r.b = 2'b10;
            check("reset outputs", 32'(obs1()), 32'(r));
        end
        check("reset flags", 32'(bus1.flags_q), 32'h0);
        $display("reset applied flags=%b", bus1.flags_q);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) runVec(i, vecs[i]);

        // Reset during MEMWR must kill the store write at once.
        v = vecs[8];
        setInputs(v);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("memwr before reset", 32'(bus1.mem_write), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("memwr after reset", 32'(bus1.mem_write), 32'h0);
        check("state after reset", 32'(dut1.stateQ), 32'(FETCH));
        check("flags after reset", 32'(bus1.flags_q), 32'h0);
        $display("mid-MEMWR reset mem_write=%b", bus1.mem_write);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // CMP on both builds: the base ALU set treats cmd 1010 as a NOP.
        v = vecs[15];
        setInputs(v);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("ext1 cmp alu", 32'(bus1.alu_control), 32'(ALU_SUB));
        check("ext0 cmp alu", 32'(bus0.alu_control), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ext0 cmp regw", 32'(bus0.reg_write), 32'h0);
        check("ext1 cmp regw", 32'(bus1.reg_write), 32'h0);
        check("ext1 cmp flags", 32'(bus1.flags_q), 32'b0110);
        check("ext0 cmp flags", 32'(bus0.flags_q), 32'b0000);
        $display("ext compare flags ext1=%b ext0=%b", bus1.flags_q, bus0.flags_q);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
